// File: rtl/delta_enc_pkg.sv
// Shared types and helpers for the multichannel send-on-delta spike encoder.
// Helpers assume WIDTH well below 62 bits so 64-bit intermediates cannot overflow.
package delta_enc_pkg;

    localparam int unsigned EV_MAG_W = 8;
    localparam int unsigned EV_CH_W  = 16;

    typedef struct packed {
        logic                pos;
        logic                neg;
        logic [EV_MAG_W-1:0] mag;
        logic [EV_CH_W-1:0]  channel;
    } event_t;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Signed add clipped to the range of a w-bit two's-complement value.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/delta_step_quantizer.sv
// Combinational multi-level delta quantizer: step count, spike sign and next reference
// for one sample against one channel's reference and threshold.
module delta_step_quantizer
    import delta_enc_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned MAG_W     = 3
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] ref_cur,
    input  logic [WIDTH-2:0] thr,
    output logic             pos,
    output logic             neg,
    output logic [MAG_W-1:0] mag,
    output logic [WIDTH-1:0] ref_next
);

    localparam int unsigned PW = WIDTH + MAG_W;

    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]        mag_abs;
    logic [PW-1:0]         thr_ext;
    logic [PW-1:0]         step;
    logic [MAG_W-1:0]      n;
    logic signed [63:0]    delta64;
    logic [WIDTH-1:0]      ref_sat;

    always_comb begin
        diff    = $signed({sample[WIDTH-1], sample}) - $signed({ref_cur[WIDTH-1], ref_cur});
        mag_abs = diff[WIDTH] ? -diff : diff;
        thr_ext = PW'(thr);
        n       = '0;
        step    = '0;
        // Thresholds are monotonic in k, so the last passing k is the largest.
        for (int k = 1; k <= MAX_STEPS; k++) begin
            if (PW'(mag_abs) > PW'(k) * thr_ext) begin
                n    = MAG_W'(k);
                step = PW'(k) * thr_ext;
            end
        end
        if (thr == '0) n = '0;

        delta64 = diff[WIDTH] ? -$signed(64'(step)) : $signed(64'(step));
        ref_sat = WIDTH'(sat_add(64'($signed(ref_cur)), delta64, WIDTH));

        pos = (n != '0) & ~diff[WIDTH];
        neg = (n != '0) & diff[WIDTH];
        mag = n;
        if (thr == '0) begin
            ref_next = sample;
        end else if (n == '0) begin
            ref_next = ref_cur;
        end else begin
            ref_next = ref_sat;
        end
    end

endmodule

// File: rtl/delta_encoder_mc_stream.sv
// Multichannel send-on-delta spike encoder on a valid/ready stream, one event per sample.
// Optional per-channel refractory period enabled by defining DELTA_ENC_REFRACTORY_EN.
module delta_encoder_mc_stream
    import delta_enc_pkg::*;
#(
    parameter int unsigned CHANNELS       = 16,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned MAX_STEPS      = 4,
    parameter int unsigned THR_INIT       = 64,
    parameter int unsigned REFRAC_SAMPLES = 2,
    localparam int unsigned CH_W  = (CHANNELS > 1) ? clog2(CHANNELS) : 1,
    localparam int unsigned MAG_W = clog2(MAX_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sample,
    input  logic [CH_W-1:0]  in_channel,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_addr,
    input  logic [WIDTH-2:0] cfg_thr,
    input  logic             clear_ref,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_pos,
    output logic             out_neg,
    output logic [MAG_W-1:0] out_mag,
    output logic [CH_W-1:0]  out_channel
);

    logic [WIDTH-1:0] ref_q [CHANNELS];
    logic [WIDTH-2:0] thr_q [CHANNELS];
    event_t           ev_q;
    event_t           ev_d;
    logic             out_valid_q;
    logic             accept;
    logic             ch_ok;
    logic             cfg_ok;
    logic             refr_hold;
    logic [WIDTH-1:0] ref_sel;
    logic [WIDTH-2:0] thr_sel;
    logic [WIDTH-1:0] ref_next;
    logic             q_pos;
    logic             q_neg;
    logic [MAG_W-1:0] q_mag;
    logic             unused_ev;

    assign in_ready = en & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign ch_ok    = 32'(in_channel) < CHANNELS;
    assign cfg_ok   = 32'(cfg_addr) < CHANNELS;
    assign ref_sel  = ch_ok ? ref_q[in_channel] : '0;
    assign thr_sel  = ch_ok ? thr_q[in_channel] : '0;

    delta_step_quantizer #(
        .WIDTH     (WIDTH),
        .MAX_STEPS (MAX_STEPS),
        .MAG_W     (MAG_W)
    ) u_quant (
        .sample   (in_sample),
        .ref_cur  (ref_sel),
        .thr      (thr_sel),
        .pos      (q_pos),
        .neg      (q_neg),
        .mag      (q_mag),
        .ref_next (ref_next)
    );

`ifdef DELTA_ENC_REFRACTORY_EN
    localparam int unsigned RC_W = (REFRAC_SAMPLES > 1) ? clog2(REFRAC_SAMPLES + 1) : 1;

    logic [RC_W-1:0] refr_q [CHANNELS];

    assign refr_hold = ch_ok && (refr_q[in_channel] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) refr_q[i] <= '0;
        end else if (clear_ref) begin
            for (int i = 0; i < CHANNELS; i++) refr_q[i] <= '0;
        end else if (accept && ch_ok) begin
            if (refr_hold) begin
                refr_q[in_channel] <= refr_q[in_channel] - 1'b1;
            end else if (q_mag != '0) begin
                refr_q[in_channel] <= RC_W'(REFRAC_SAMPLES);
            end
        end
    end
`else
    logic unused_refrac;
    assign refr_hold     = 1'b0;
    assign unused_refrac = ^REFRAC_SAMPLES;
`endif

    always_comb begin
        ev_d         = '0;
        ev_d.channel = EV_CH_W'(in_channel);
        if (ch_ok && !refr_hold) begin
            ev_d.pos = q_pos;
            ev_d.neg = q_neg;
            ev_d.mag = EV_MAG_W'(q_mag);
        end
    end

    // Refill on the same edge the held event drains keeps one event per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ev_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ev_q        <= ev_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) thr_q[i] <= (WIDTH-1)'(THR_INIT);
        end else if (cfg_we && cfg_ok) begin
            thr_q[cfg_addr] <= cfg_thr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) ref_q[i] <= '0;
        end else if (clear_ref) begin
            for (int i = 0; i < CHANNELS; i++) ref_q[i] <= '0;
        end else if (accept && ch_ok && !refr_hold) begin
            ref_q[in_channel] <= ref_next;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pos     = ev_q.pos;
    assign out_neg     = ev_q.neg;
    assign out_mag     = ev_q.mag[MAG_W-1:0];
    assign out_channel = ev_q.channel[CH_W-1:0];
    assign unused_ev   = ^ev_q;

endmodule

// File: tb/tb_delta_encoder_mc_stream.sv
// Self-checking bench for delta_encoder_mc_stream: vector table plus hand-written
// sequences, with a scoreboard queue checked against every output handshake.
module tb_delta_encoder_mc_stream;

    localparam int unsigned CHANNELS  = 12;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned MAX_STEPS = 4;
    localparam int unsigned THR_INIT  = 64;
    localparam int CH_W  = 4;
    localparam int MAG_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_sample = '0;
    logic [CH_W-1:0]  in_channel = '0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_addr = '0;
    logic [WIDTH-2:0] cfg_thr = '0;
    logic             clear_ref = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_pos;
    logic             out_neg;
    logic [MAG_W-1:0] out_mag;
    logic [CH_W-1:0]  out_channel;

    delta_encoder_mc_stream #(
        .CHANNELS       (CHANNELS),
        .WIDTH          (WIDTH),
        .MAX_STEPS      (MAX_STEPS),
        .THR_INIT       (THR_INIT),
        .REFRAC_SAMPLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample   (in_sample),
        .in_channel  (in_channel),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_thr     (cfg_thr),
        .clear_ref   (clear_ref),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pos     (out_pos),
        .out_neg     (out_neg),
        .out_mag     (out_mag),
        .out_channel (out_channel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int neg;
        int mag;
        int ch;
    } exp_t;

    typedef struct {
        int ch;
        int smp;
        int do_cfg;
        int thr;
        int pos;
        int neg;
        int mag;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: outputs sampled mid low phase, handshake completes next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got ch %0d mag %0d, expected none",
                             out_channel, out_mag);
                end else begin
                    e = sb.pop_front();
                    check("ev_pos", int'(out_pos), e.pos);
                    check("ev_neg", int'(out_neg), e.neg);
                    check("ev_mag", int'(out_mag), e.mag);
                    check("ev_ch", int'(out_channel), e.ch);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input int thr);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = CH_W'(ch);
        cfg_thr  = (WIDTH-1)'(thr);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input int ch, input int smp, input int ep, input int eneg, input int em,
                        input logic clr = 1'b0, input logic cfg = 1'b0, input int cthr = 0);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_channel = CH_W'(ch);
        in_sample  = WIDTH'(smp);
        clear_ref  = clr;
        cfg_we     = cfg;
        cfg_addr   = CH_W'(ch);
        cfg_thr    = (WIDTH-1)'(cthr);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", waited);
        end else begin
            e.pos = ep;
            e.neg = eneg;
            e.mag = em;
            e.ch  = ch;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_ref = 1'b0;
        cfg_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_mag", int'(out_mag), 0);
        check("rst_pos", int'(out_pos), 0);
        check("rst_ch", int'(out_channel), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

`ifndef DELTA_ENC_REFRACTORY_EN
        // {ch, sample, cfg first?, thr, pos, neg, mag}
        vt.push_back('{3, 200, 0, 0, 1, 0, 3});
        vt.push_back('{3, 100, 0, 0, 0, 1, 1});
        vt.push_back('{3, 130, 0, 0, 0, 0, 0});
        vt.push_back('{0, -64, 0, 0, 0, 0, 0});
        vt.push_back('{0, -65, 0, 0, 0, 1, 1});
        vt.push_back('{1, 1000, 0, 0, 1, 0, 4});
        vt.push_back('{13, 5000, 0, 0, 0, 0, 0});
        vt.push_back('{1, 256, 0, 0, 0, 0, 0});
        vt.push_back('{11, -32768, 0, 0, 0, 1, 4});
        vt.push_back('{7, 16001, 1, 4000, 1, 0, 4});
        vt.push_back('{7, 32767, 1, 16384, 1, 0, 1});
        vt.push_back('{7, 32767, 0, 0, 0, 0, 0});
        vt.push_back('{7, -32768, 0, 0, 0, 1, 3});
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].do_cfg != 0) cfg_write(vt[i].ch, vt[i].thr);
            send(vt[i].ch, vt[i].smp, vt[i].pos, vt[i].neg, vt[i].mag);
        end

        // Threshold write on the same edge as a sample: old thr used, new thr afterwards.
        send(5, 500, 1, 0, 4, 1'b0, 1'b1, 0);
        send(5, 300, 0, 0, 0);
        cfg_write(5, 64);
        send(5, 235, 0, 1, 1);

        // clear_ref with an accept: event uses old ref 128, ref then 0.
        send(3, 330, 1, 0, 3, 1'b1);
        send(3, 65, 1, 0, 1);

        // Global enable low stalls the input.
        @(negedge clk);
        en         = 1'b0;
        in_valid   = 1'b1;
        in_channel = 4'd2;
        in_sample  = 16'd500;
        #2;
        check("en_low_ready", int'(in_ready), 0);
        @(negedge clk);
        #1;
        check("en_low_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        en       = 1'b1;

        // Backpressure: held event stable for 5 cycles, then back-to-back drain/refill.
        idle(1);
        out_ready = 1'b0;
        send(2, 70, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_channel = 4'd2;
            in_sample  = 16'd200;
            #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_valid", int'(out_valid), 1);
            check("bp_mag", int'(out_mag), 1);
            check("bp_pos", int'(out_pos), 1);
            check("bp_ch", int'(out_channel), 2);
            if (i == 4) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
        end
        send(2, 200, 1, 0, 2);
        send(2, 0, 0, 1, 2);
`endif

        // Asynchronous reset mid-transfer.
        send(4, 1000, 1, 0, 4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_mag", int'(out_mag), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(7, 200, 1, 0, 3);

`ifdef DELTA_ENC_REFRACTORY_EN
        send(6, 200, 1, 0, 3);
        send(6, 400, 0, 0, 0);
        send(6, 400, 0, 0, 0);
        send(6, 400, 1, 0, 3);
`endif

        idle(3);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
